// File: rtl/pc_fetch_unit_pkg.sv
// pc_fetch_unit_pkg
//   Shared definitions for the Lab2 RV32I program-counter / fetch unit:
//   fetch FSM state encoding, the NOP instruction loaded on reset and the
//   default ecall id that halts the core.
package pc_fetch_unit_pkg;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_HALT  = 2'd2
    } fetch_state_t;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    // x17 value that turns an ecall into a halt request
    localparam int unsigned ECALL_HALT_ID_DEFAULT = 10;

endpackage

// File: rtl/pc_fetch_unit_next_pc.sv
// next_pc_calc
//   Purely combinational next-PC selection for the fetch unit.
//   Priority (highest first): jalr, jal, taken branch, fall-through pc+4.
//   All adds wrap modulo 2^XLEN.
// Ports:
//   pc        in  XLEN  current program counter
//   imm       in  XLEN  sign-extended immediate
//   rs1_data  in  XLEN  jalr base register value
//   is_jal, is_jalr, branch, is_ecall, bcond  in 1 each  control decisions
//   next_pc   out XLEN  selected next program counter
//   pc_plus4  out XLEN  pc + 4 (link value)
module next_pc_calc #(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] rs1_data,
    input  logic            is_jal,
    input  logic            is_jalr,
    input  logic            branch,
    input  logic            is_ecall,
    input  logic            bcond,
    output logic [XLEN-1:0] next_pc,
    output logic [XLEN-1:0] pc_plus4
);

    logic [XLEN-1:0] pc_rel;
    logic [XLEN-1:0] jalr_sum;
    logic            unused_ecall;

    // ecall always continues at pc+4; its halting effect lives in the FSM
    assign unused_ecall = is_ecall;

    assign pc_plus4 = pc + XLEN'(4);
    assign pc_rel   = pc + imm;
    assign jalr_sum = rs1_data + imm;

    always_comb begin
        next_pc = pc_plus4;
        if (is_jalr) begin
            next_pc = {jalr_sum[XLEN-1:1], 1'b0};
        end else if (is_jal) begin
            next_pc = pc_rel;
        end else if (branch && bcond) begin
            next_pc = pc_rel;
        end
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit
//   Owns the PC and the instruction-memory fetch handshake of the Lab2
//   RV32I core. Fetches one instruction, holds it while downstream logic
//   executes it, then advances the PC from the control/ALU decisions.
//   A halting ecall (x17 == ECALL_HALT_ID) parks the FSM in HALT until reset.
//   Optional build macro: PC_MISALIGN_TRAP_EN -- a misaligned next PC halts
//   the core with misalign_trap set; otherwise misalign_trap is tied low.
// Ports:
//   clk, reset (async, active-low)
//   imem_req/imem_addr/imem_ready/imem_rdata  instruction-memory handshake
//   inst, inst_valid        held instruction and its executing flag
//   exec_done               downstream commit of the current instruction
//   is_jal, is_jalr, branch, is_ecall, bcond, imm, rs1_data, x17_data
//                           next-PC / halt decision inputs
//   pc, pc_plus4            current PC and link value
//   is_halted, misalign_trap  sticky status flags
module pc_fetch_unit
    import pc_fetch_unit_pkg::*;
#(
    parameter int unsigned     XLEN          = 32,
    parameter logic [XLEN-1:0] RESET_PC      = '0,
    parameter int unsigned     ECALL_HALT_ID = ECALL_HALT_ID_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic [31:0]     imem_rdata,
    output logic [31:0]     inst,
    output logic            inst_valid,
    input  logic            exec_done,
    input  logic            is_jal,
    input  logic            is_jalr,
    input  logic            branch,
    input  logic            is_ecall,
    input  logic            bcond,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] x17_data,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    output logic            is_halted,
    output logic            misalign_trap
);

    localparam logic [XLEN-1:0] HALT_ID = XLEN'(ECALL_HALT_ID);

    fetch_state_t    state;
    fetch_state_t    state_next;
    logic [XLEN-1:0] pc_q;
    logic [31:0]     inst_q;
    logic [XLEN-1:0] next_pc;
    logic            load_inst;
    logic            load_pc;
    logic            halt_ecall;

    next_pc_calc #(
        .XLEN(XLEN)
    ) u_next_pc (
        .pc       (pc_q),
        .imm      (imm),
        .rs1_data (rs1_data),
        .is_jal   (is_jal),
        .is_jalr  (is_jalr),
        .branch   (branch),
        .is_ecall (is_ecall),
        .bcond    (bcond),
        .next_pc  (next_pc),
        .pc_plus4 (pc_plus4)
    );

    assign halt_ecall = is_ecall && (x17_data == HALT_ID);

`ifdef PC_MISALIGN_TRAP_EN
    logic target_misaligned;
    logic set_trap;
    logic trap_q;

    assign target_misaligned = (next_pc[1:0] != 2'b00);
`endif

    always_comb begin
        state_next = state;
        imem_req   = 1'b0;
        inst_valid = 1'b0;
        load_inst  = 1'b0;
        load_pc    = 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
        set_trap   = 1'b0;
`endif
        case (state)
            ST_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    load_inst  = 1'b1;
                    state_next = ST_EXEC;
                end
            end
            ST_EXEC: begin
                inst_valid = 1'b1;
                if (exec_done) begin
                    // pc advances even on the halting ecall, so debug sees pc+4
                    load_pc = 1'b1;
                    if (halt_ecall) begin
                        state_next = ST_HALT;
                    end else begin
                        state_next = ST_FETCH;
                    end
`ifdef PC_MISALIGN_TRAP_EN
                    if (target_misaligned) begin
                        state_next = ST_HALT;
                        set_trap   = 1'b1;
                    end
`endif
                end
            end
            ST_HALT: begin
                state_next = ST_HALT;
            end
            default: begin
                state_next = ST_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= ST_FETCH;
            pc_q   <= RESET_PC;
            inst_q <= NOP_INST;
        end else begin
            state <= state_next;
            if (load_inst) begin
                inst_q <= imem_rdata;
            end
            if (load_pc) begin
                pc_q <= next_pc;
            end
        end
    end

`ifdef PC_MISALIGN_TRAP_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            trap_q <= 1'b0;
        end else if (set_trap) begin
            trap_q <= 1'b1;
        end
    end

    assign misalign_trap = trap_q;
`else
    assign misalign_trap = 1'b0;
`endif

    assign pc        = pc_q;
    assign imem_addr = pc_q;
    assign inst      = inst_q;
    // HALT is only left through reset, so the state itself is the sticky flag
    assign is_halted = (state == ST_HALT);

endmodule
